// File: rtl/vedic_pkg.sv
// Shared types and helpers for the sequential Vedic multiply-accumulate block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vedic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Accumulator width: full product plus guard bits.
    function automatic int vedic_ow(input int width, input int acc_bits);
        return 2 * width + acc_bits;
    endfunction

endpackage

// File: rtl/vedic_row_mult.sv
// Multiplies a WIDTH-bit operand by one 2-bit digit using WIDTH/2 Vedic 2x2 cells.
// Latency: combinational.
// Backpressure: none.
module vedic_row_mult #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [1:0]       i_b,
    output logic [WIDTH+1:0] o_row
);

    localparam int ND = WIDTH / 2;

    logic [3:0] w_dig [ND];

    for (genvar gi = 0; gi < ND; gi++) begin : g_cell
        vedicmultiplier_2bit u_cell (
            .i_a (i_a[2*gi +: 2]),
            .i_b (i_b),
            .o_p (w_dig[gi])
        );
    end

    // Shift each digit product into its position and sum; the total never exceeds WIDTH+2 bits.
    always_comb begin
        o_row = '0;
        for (int j = 0; j < ND; j++) begin
            o_row = o_row + ((WIDTH + 2)'(w_dig[j]) << (2 * j));
        end
    end

endmodule

// File: rtl/vedicmultiplier_2bit.sv
// 2x2 unsigned Vedic (Urdhva-Tiryakbhyam) multiplier cell.
// Latency: combinational.
// Backpressure: none.
module vedicmultiplier_2bit (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic [3:0] o_p
);

    logic w_cross0;
    logic w_cross1;
    logic w_vert1;
    logic w_c1;

    assign w_cross0 = i_a[1] & i_b[0];
    assign w_cross1 = i_a[0] & i_b[1];
    assign w_vert1  = i_a[1] & i_b[1];
    assign w_c1     = w_cross0 & w_cross1;

    // Vertical and crosswise partial products combined with two half adders.
    assign o_p[0] = i_a[0] & i_b[0];
    assign o_p[1] = w_cross0 ^ w_cross1;
    assign o_p[2] = w_vert1 ^ w_c1;
    assign o_p[3] = w_vert1 & w_c1;

endmodule

// File: rtl/vedicmultiplier_mac_seq.sv
// Sequential unsigned multiply-accumulate, one 2-bit multiplier digit per cycle.
// Latency: WIDTH/2 edges from accept to outValid.
// Backpressure: result held in DONE until outReady; inReady only in IDLE.
module vedicmultiplier_mac_seq
    import vedic_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ACC_BITS = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     inValid,
    output logic                                     inReady,
    input  logic [WIDTH-1:0]                         inData_A,
    input  logic [WIDTH-1:0]                         inData_B,
    input  logic                                     inAccumulate,
    output logic                                     outValid,
    input  logic                                     outReady,
    output logic [vedic_ow(WIDTH, ACC_BITS)-1:0]     outData_C,
    output logic                                     outOverflow
);

    localparam int OW = vedic_ow(WIDTH, ACC_BITS);
    localparam int ND = WIDTH / 2;
    localparam int KW = (ND > 1) ? $clog2(ND) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [KW-1:0]       r_k;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic                r_acc;
    logic [2*WIDTH-1:0]  r_pp;
    logic [OW-1:0]       r_c;
    logic                r_ovf;

    logic [WIDTH-1:0]    w_b_shift;
    logic [WIDTH+1:0]    w_row;
    logic [2*WIDTH-1:0]  w_row_shift;
    logic [2*WIDTH-1:0]  w_pp_next;
    logic [OW:0]         w_sum;
    logic                w_last;

    // Select multiplier digit k and form its row product.
    assign w_b_shift = r_b >> {r_k, 1'b0};

    vedic_row_mult #(.WIDTH(WIDTH)) u_row (
        .i_a   (r_a),
        .i_b   (w_b_shift[1:0]),
        .o_row (w_row)
    );

    assign w_row_shift = (2 * WIDTH)'(w_row) << {r_k, 1'b0};
    assign w_pp_next   = r_pp + w_row_shift;
    assign w_last      = (r_k == KW'(ND - 1));
    // One extra bit catches the carry out of the accumulator.
    assign w_sum       = (r_acc ? {1'b0, r_c} : '0) + (OW + 1)'(w_pp_next);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, iterate digits in BUSY, hold result in DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (inValid)  w_state_nxt = BUSY;
            BUSY:    if (w_last)   w_state_nxt = DONE;
            DONE:    if (outReady) w_state_nxt = IDLE;
            default:               w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, digit iteration and accumulator update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k   <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= 1'b0;
            r_pp  <= '0;
            r_c   <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (inValid) begin
                        r_a   <= inData_A;
                        r_b   <= inData_B;
                        r_acc <= inAccumulate;
                        r_pp  <= '0;
                        r_k   <= '0;
                    end
                end
                BUSY: begin
                    r_pp <= w_pp_next;
                    r_k  <= r_k + KW'(1);
                    if (w_last) begin
                        r_c   <= w_sum[OW-1:0];
                        // Overflow is sticky across an accumulation chain, cleared by a fresh start.
                        r_ovf <= r_acc ? (r_ovf | w_sum[OW]) : 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign inReady     = (r_state == IDLE);
    assign outValid    = (r_state == DONE);
    assign outData_C   = r_c;
    assign outOverflow = r_ovf;

endmodule

// File: tb/tb_vedicmultiplier_mac_seq.sv
// Directed self-checking bench for vedicmultiplier_mac_seq (WIDTH=8, ACC_BITS=4).
// Latency: n/a.
// Backpressure: exercised by holding outReady low in DONE.
module tb_vedicmultiplier_mac_seq;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic        inValid      = 1'b0;
    logic        inAccumulate = 1'b0;
    logic        outReady     = 1'b0;
    logic [7:0]  a            = 8'd0;
    logic [7:0]  b            = 8'd0;
    logic        inReady;
    logic        outValid;
    logic [19:0] c;
    logic        ovf;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    always #5 clk = ~clk;

    vedicmultiplier_mac_seq #(.WIDTH(8), .ACC_BITS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inValid      (inValid),
        .inReady      (inReady),
        .inData_A     (a),
        .inData_B     (b),
        .inAccumulate (inAccumulate),
        .outValid     (outValid),
        .outReady     (outReady),
        .outData_C    (c),
        .outOverflow  (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [7:0] ta, input logic [7:0] tb, input logic tacc);
        int n;
        n = 0;
        while (!inReady && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", {31'd0, inReady}, 32'd1);
        a = ta;
        b = tb;
        inAccumulate = tacc;
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!outValid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tacc, input logic [19:0] ec, input logic eovf);
        int lat;
        accept(ta, tb, tacc);
        wait_done(lat);
        check({tag, "_lat"}, lat, 32'd4);
        check({tag, "_c"}, {12'd0, c}, {12'd0, ec});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        check({tag, "_idle"}, {31'd0, inReady}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] exp_sum;

        // Reset state.
        #12;
        check("rst_c", {12'd0, c}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_valid", {31'd0, outValid}, 32'd0);
        check("rst_ready", {31'd0, inReady}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single multiply.
        run_op("ffxff", 8'hFF, 8'hFF, 1'b0, 20'h0FE01, 1'b0);

        // Accumulation chain.
        run_op("3x5", 8'd3, 8'd5, 1'b0, 20'd15, 1'b0);
        run_op("10x10acc", 8'd10, 8'd10, 1'b1, 20'd115, 1'b0);

        // Overflow: 16 products fit, the 17th wraps.
        for (int i = 1; i <= 16; i++) begin
            exp_sum = 32'(i) * 32'd65025;
            run_op($sformatf("ovf%0d", i), 8'hFF, 8'hFF, (i != 1), exp_sum[19:0], 1'b0);
        end
        run_op("ovf17", 8'hFF, 8'hFF, 1'b1, 20'd56849, 1'b1);
        run_op("ovf_hold", 8'd1, 8'd1, 1'b1, 20'd56850, 1'b1);
        run_op("ovf_clear", 8'd1, 8'd1, 1'b0, 20'd1, 1'b0);

        // Zero operand still takes the full latency.
        run_op("zero", 8'd0, 8'h55, 1'b0, 20'd0, 1'b0);

        // Backpressure in DONE with inValid pulsed.
        accept(8'd6, 8'd7, 1'b0);
        wait_done(lat);
        check("bp_lat", lat, 32'd4);
        check("bp_c", {12'd0, c}, 32'd42);
        for (int i = 0; i < 5; i++) begin
            a = 8'hAA;
            b = 8'hBB;
            inAccumulate = 1'b0;
            inValid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("bp_hold_c%0d", i), {12'd0, c}, 32'd42);
            check($sformatf("bp_hold_rdy%0d", i), {31'd0, inReady}, 32'd0);
            check($sformatf("bp_hold_vld%0d", i), {31'd0, outValid}, 32'd1);
        end
        inValid = 1'b0;
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        check("bp_release_rdy", {31'd0, inReady}, 32'd1);
        check("bp_release_vld", {31'd0, outValid}, 32'd0);
        check("bp_release_c", {12'd0, c}, 32'd42);
        // Accumulating onto 42 proves the pulsed operands were not captured.
        run_op("bp_after", 8'd1, 8'd1, 1'b1, 20'd43, 1'b0);

        // Reset in the middle of an operation.
        accept(8'd7, 8'd9, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_c", {12'd0, c}, 32'd0);
        check("midrst_ovf", {31'd0, ovf}, 32'd0);
        check("midrst_vld", {31'd0, outValid}, 32'd0);
        check("midrst_rdy", {31'd0, inReady}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("rst_acc", 8'd2, 8'd3, 1'b1, 20'd6, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
